// File: rtl/wb_bus_arbiter_ctrl.sv
// rtl/wb_bus_arbiter_ctrl.sv - round-robin Wishbone arbiter with decode-error check and hang watchdog
// Watchdog/timeout path is built only when WB_ARB_WATCHDOG_EN is defined.
module wb_bus_arbiter_ctrl #(
  parameter int MASTER_NUM  = 4,
  parameter int SLAVE_NUM   = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8,
  parameter int MID_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_NUM-1:0] m_cyc,
  input  logic [MASTER_NUM-1:0] m_stb,
  input  logic [SLAVE_NUM-1:0]  s_sel,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  output logic [MASTER_NUM-1:0] grant,
  output logic [MID_W-1:0]      grant_id,
  output logic                  bus_busy,
  output logic                  arb_err,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    TERM = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [MID_W-1:0]      grant_id_q, grant_id_d;
  logic [MID_W-1:0]      last_q, last_d;
  logic                  bus_busy_q, bus_busy_d;
  logic                  arb_err_q, arb_err_d;
  logic                  timeout_flag_q, timeout_flag_d;

  logic [MID_W-1:0]      pick_id;
  logic                  pick_vld;
  logic                  own_cyc;
  logic                  own_stb;
  logic                  dec_err;
  logic                  wd_hit;

`ifdef WB_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  assign wd_hit = (wd_q == TIMEOUT_W'(TIMEOUT_CYC));
`else
  logic                  unused_wd;
  assign wd_hit    = 1'b0;
  assign unused_wd = ^{bus_ack, bus_err, TIMEOUT_W'(TIMEOUT_CYC)};
`endif

  assign own_cyc = m_cyc[grant_id_q];
  assign own_stb = m_stb[grant_id_q];
  assign dec_err = own_stb && !$onehot(s_sel);

  // First requester strictly after the last owner, wrapping around.
  always_comb begin
    logic [MID_W-1:0] cand;
    cand     = '0;
    pick_id  = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      if (int'(last_q) + i >= MASTER_NUM)
        cand = MID_W'(int'(last_q) + i - MASTER_NUM);
      else
        cand = MID_W'(int'(last_q) + i);
      if (!pick_vld && m_cyc[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    last_d         = last_q;
    bus_busy_d     = bus_busy_q;
    arb_err_d      = 1'b0;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUS;
          grant_d    = MASTER_NUM'(1) << pick_id;
          grant_id_d = pick_id;
          last_d     = pick_id;
          bus_busy_d = 1'b1;
        end
      end
      BUS: begin
        // A decode error masks a coincident timeout: one pulse, no sticky flag.
        if (dec_err) begin
          arb_err_d = 1'b1;
          state_d   = TERM;
        end else if (wd_hit) begin
          arb_err_d      = 1'b1;
          timeout_flag_d = 1'b1;
          state_d        = TERM;
        end else if (!own_cyc) begin
          state_d = TERM;
        end
        if (state_d == TERM) begin
          grant_d    = '0;
          bus_busy_d = 1'b0;
        end
      end
      TERM: begin
        state_d    = IDLE;
        grant_d    = '0;
        bus_busy_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        bus_busy_d = 1'b0;
      end
    endcase
`ifdef WB_ARB_WATCHDOG_EN
    wd_d = '0;
    if (state_q == BUS && state_d == BUS && own_stb && !bus_ack && !bus_err)
      wd_d = wd_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      grant_id_q     <= '0;
      last_q         <= MID_W'(MASTER_NUM - 1);
      bus_busy_q     <= 1'b0;
      arb_err_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
`ifdef WB_ARB_WATCHDOG_EN
      wd_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      last_q         <= last_d;
      bus_busy_q     <= bus_busy_d;
      arb_err_q      <= arb_err_d;
      timeout_flag_q <= timeout_flag_d;
`ifdef WB_ARB_WATCHDOG_EN
      wd_q           <= wd_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign bus_busy     = bus_busy_q;
  assign arb_err      = arb_err_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_wb_bus_arbiter_ctrl.sv
// tb/tb_wb_bus_arbiter_ctrl.sv - self-checking bench for wb_bus_arbiter_ctrl
module tb_wb_bus_arbiter_ctrl;

  localparam int TMO = 4;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] m_cyc = '0;
  logic [3:0] m_stb = '0;
  logic [2:0] s_sel = '0;
  logic       bus_ack = 1'b0;
  logic       bus_err = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       arb_err;
  logic       timeout_flag;

  wb_bus_arbiter_ctrl #(
    .MASTER_NUM(4), .SLAVE_NUM(3), .TIMEOUT_CYC(TMO), .TIMEOUT_W(8), .MID_W(2)
  ) dut (
    .clk(clk), .reset(reset), .m_cyc(m_cyc), .m_stb(m_stb), .s_sel(s_sel),
    .bus_ack(bus_ack), .bus_err(bus_err), .grant(grant), .grant_id(grant_id),
    .bus_busy(bus_busy), .arb_err(arb_err), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit use_model = 1'b0;

  // Reference: who owns the bus, whether we are in the dead cycle, and the stall count.
  int mdl_owner_valid, mdl_dead, mdl_id, mdl_last, mdl_stall, mdl_err, mdl_tflag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner_valid = 0; mdl_dead = 0; mdl_id = 0; mdl_last = 3;
    mdl_stall = 0; mdl_err = 0; mdl_tflag = 0;
  endtask

  task automatic model_step();
    bit found;
    bit bad;
    bit tout;
    bit stalled;
    mdl_err = 0;
    if (mdl_dead != 0) begin
      mdl_dead = 0;
    end else if (mdl_owner_valid == 0) begin
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && m_cyc[(mdl_last + i) % 4]) begin
          found = 1'b1;
          mdl_id = (mdl_last + i) % 4;
          mdl_last = mdl_id;
          mdl_owner_valid = 1;
          mdl_stall = 0;
        end
      end
    end else begin
      bad = m_stb[mdl_id] && ($countones(s_sel) != 1);
      tout = WD_EN && (mdl_stall == TMO);
      stalled = m_stb[mdl_id] && !bus_ack && !bus_err;
      if (bad || tout || !m_cyc[mdl_id]) begin
        mdl_owner_valid = 0;
        mdl_dead = 1;
        mdl_err = (bad || tout) ? 1 : 0;
        if (!bad && tout) mdl_tflag = 1;
      end
      mdl_stall = (mdl_owner_valid != 0 && stalled) ? mdl_stall + 1 : 0;
    end
  endtask

  task automatic cycle();
    logic [3:0] eg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (use_model) begin
      eg = (mdl_owner_valid != 0) ? (4'b0001 << mdl_id) : 4'b0000;
      chk("mdl_grant", grant, eg);
      chk("mdl_grant_id", grant_id, mdl_id);
      chk("mdl_bus_busy", bus_busy, mdl_owner_valid);
      chk("mdl_arb_err", arb_err, mdl_err);
      chk("mdl_timeout_flag", timeout_flag, mdl_tflag);
    end
  endtask

  // Called at a falling edge; asserts reset between clock edges.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_bus_busy", bus_busy, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_grant_id", grant_id, 0);
    model_reset();
    m_cyc = '0; m_stb = '0; s_sel = '0; bus_ack = 1'b0; bus_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic [2:0] sel;
    logic       ack;
    logic       err;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       aerr;
    logic       tf;
  } vec_t;

  vec_t tbl [12];
  int order [5];
  int ng, own, pulses, held;

  initial begin
    tbl[0]  = '{4'b0100, 4'b0100, 3'b001, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 3'b001, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 4'b0010, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0010, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, 3'b011, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

    do_reset();

    use_model = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb; s_sel = tbl[i].sel;
      bus_ack = tbl[i].ack; bus_err = tbl[i].err;
      cycle();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_grant_id", i), grant_id, tbl[i].id);
      chk($sformatf("tbl%0d_bus_busy", i), bus_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_arb_err", i), arb_err, tbl[i].aerr);
      chk($sformatf("tbl%0d_timeout_flag", i), timeout_flag, tbl[i].tf);
    end
    use_model = 1'b1;

    // Fairness: everyone requests, each owner lets go after three cycles.
    do_reset();
    ng = 0; own = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      m_cyc = (own >= 3) ? (4'b1111 & ~grant) : 4'b1111;
      cycle();
      if (grant != 4'b0000) begin
        if (own == 0) begin
          order[ng] = grant_id;
          ng++;
        end
        own++;
      end else begin
        own = 0;
      end
    end
    chk("rr_grants_seen", ng, 5);
    for (int k = 0; k < ng; k++) chk($sformatf("rr_order%0d", k), order[k], k % 4);
    m_cyc = '0;
    cycle(); cycle(); cycle();

    // Hung slave: strobe held, no ack.
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001; s_sel = 3'b001;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (arb_err) pulses++;
    end
    chk("tmo_pulses", pulses, WD_EN ? 1 : 0);
    chk("tmo_flag", timeout_flag, WD_EN ? 1 : 0);
    chk("tmo_grant", grant, 4'b0001);
    m_stb = 4'b0000;
    cycle(); cycle(); cycle();
    chk("tmo_flag_sticky", timeout_flag, WD_EN ? 1 : 0);
    chk("tmo_bus_held", bus_busy, 1);

    // Asynchronous reset in the middle of an owned transfer, then immediate re-grant.
    do_reset();
    m_cyc = 4'b0010;
    cycle();
    chk("postrst_grant", grant, 4'b0010);
    chk("postrst_grant_id", grant_id, 1);
    m_cyc = '0;
    cycle(); cycle(); cycle();

    // Periodic acks keep the watchdog from expiring.
    do_reset();
    m_cyc = 4'b1000; m_stb = 4'b1000; s_sel = 3'b010;
    cycle();
    pulses = 0; held = 0;
    for (int c = 0; c < 20; c++) begin
      bus_ack = (c % 3 == 2);
      cycle();
      if (arb_err) pulses++;
      if (grant == 4'b1000) held++;
    end
    chk("ack_no_err", pulses, 0);
    chk("ack_grant_held", held, 20);
    bus_ack = 1'b0; m_cyc = '0; m_stb = '0;
    cycle(); cycle();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) m_cyc[b] = ~m_cyc[b];
      m_stb = 4'($urandom) & m_cyc;
      if ($urandom_range(3) != 0) s_sel = 3'b001 << $urandom_range(2);
      else s_sel = 3'($urandom);
      bus_ack = ($urandom_range(3) == 0);
      bus_err = ($urandom_range(19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
